// File: rtl/test_runner.sv
// test_runner: CI harness controller. It drives the bench-side reset pulse,
// collects sticky per-bench fail/finish flags, enforces a run-length timeout
// and publishes a registered pass/done verdict.
module test_runner #(
  parameter int unsigned NUM_TESTS    = 1,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] TIMEOUT      = 32'd1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_TESTS-1:0] fail,
  input  logic [NUM_TESTS-1:0] finish,
  output logic                 dut_reset,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] finish_mask,
  output logic [31:0]          cycles
);

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_DONE} state_t;

  localparam logic [8:0]  RC_LAST  = 9'(RESET_CYCLES);
  localparam logic [32:0] TMO_LAST = {1'b0, TIMEOUT};

  state_t               state;
  logic [7:0]           rst_cnt;
  logic [NUM_TESTS-1:0] next_fail;
  logic [NUM_TESTS-1:0] next_finish;
  logic [32:0]          cycles_inc;
  logic                 rst_last;
  logic                 all_finished;
  logic                 hit_timeout;

  // Flags as they will look after this edge's RUN sample; the verdict is
  // formed from these so a fail arriving with the last finish still counts.
  assign next_fail    = fail_mask | fail;
  assign next_finish  = finish_mask | finish;
  assign cycles_inc   = {1'b0, cycles} + 33'd1;
  assign rst_last     = ({1'b0, rst_cnt} + 9'd1) == RC_LAST;
  assign all_finished = &next_finish;
  assign hit_timeout  = cycles_inc == TMO_LAST;

  // Runner state machine: RST pulse, RUN collection, frozen DONE verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RST;
      rst_cnt     <= '0;
      dut_reset   <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_mask   <= '0;
      finish_mask <= '0;
      cycles      <= '0;
    end else begin
      case (state)
        ST_RST: begin
          rst_cnt <= rst_cnt + 8'd1;
          if (rst_last) begin
            state     <= ST_RUN;
            dut_reset <= 1'b0;
          end
        end
        ST_RUN: begin
          fail_mask   <= next_fail;
          finish_mask <= next_finish;
          cycles      <= cycles_inc[31:0];
          // Finishing wins over a timeout landing on the same edge.
          if (all_finished) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
            pass    <= ~|next_fail;
          end else if (hit_timeout) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_runner.sv
// tb_test_runner: directed and randomized checks of test_runner against a
// scenario-level model (per-bench finish/fail edges -> expected verdict).
module tb_test_runner;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: one bench, short timeout.
  logic        reset_a, dut_reset_a, done_a, pass_a, timeout_a;
  logic [0:0]  fail_a, finish_a, fail_mask_a, finish_mask_a;
  logic [31:0] cycles_a;

  // Instance B: two benches, longer reset and timeout.
  localparam int RC_B  = 3;
  localparam int TMO_B = 12;
  logic        reset_b, dut_reset_b, done_b, pass_b, timeout_b;
  logic [1:0]  fail_b, finish_b, fail_mask_b, finish_mask_b;
  logic [31:0] cycles_b;

  test_runner #(.NUM_TESTS(1), .RESET_CYCLES(2), .TIMEOUT(32'd5)) u_a (
    .clock(clock), .reset(reset_a), .fail(fail_a), .finish(finish_a),
    .dut_reset(dut_reset_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
    .fail_mask(fail_mask_a), .finish_mask(finish_mask_a), .cycles(cycles_a));

  test_runner #(.NUM_TESTS(2), .RESET_CYCLES(RC_B), .TIMEOUT(TMO_B)) u_b (
    .clock(clock), .reset(reset_b), .fail(fail_b), .finish(finish_b),
    .dut_reset(dut_reset_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
    .fail_mask(fail_mask_b), .finish_mask(finish_mask_b), .cycles(cycles_b));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic dr, input logic dn, input logic ps,
                         input logic tm, input logic fm, input logic nm, input int cy);
    check({tag, ".dut_reset"}, 32'(dut_reset_a), 32'(dr));
    check({tag, ".done"}, 32'(done_a), 32'(dn));
    check({tag, ".pass"}, 32'(pass_a), 32'(ps));
    check({tag, ".timeout"}, 32'(timeout_a), 32'(tm));
    check({tag, ".fail_mask"}, 32'(fail_mask_a), 32'(fm));
    check({tag, ".finish_mask"}, 32'(finish_mask_a), 32'(nm));
    check({tag, ".cycles"}, cycles_a, 32'(cy));
  endtask

  // Reset A, release, and walk through the 2-edge dut_reset pulse into RUN.
  task automatic start_a(input string tag);
    reset_a = 1'b1;
    repeat (3) tick();
    check_a({tag, ".rst"}, 1, 0, 0, 0, 0, 0, 0);
    reset_a = 1'b0;
    tick();
    check({tag, ".dr_e0"}, 32'(dut_reset_a), 32'd1);
    tick();
    check({tag, ".dr_e1"}, 32'(dut_reset_a), 32'd0);
    check({tag, ".masks_rst"}, 32'({fail_mask_a, finish_mask_a}), 32'd0);
  endtask

  task automatic start_b(input string tag);
    reset_b = 1'b1;
    repeat (2) tick();
    check({tag, ".rst_done"}, 32'(done_b), 32'd0);
    check({tag, ".rst_cycles"}, cycles_b, 32'd0);
    reset_b = 1'b0;
    check({tag, ".dr_pre"}, 32'(dut_reset_b), 32'd1);
    for (int k = 0; k < RC_B; k++) begin
      tick();
      check({tag, ".dr"}, 32'(dut_reset_b), (k < RC_B - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int fe[2];
    int fl[2];
    int last, fin_e;
    logic tmo;
    logic [1:0] fm, nm;

    reset_a = 1'b1; fail_a = '0; finish_a = '0;
    reset_b = 1'b1; fail_b = '0; finish_b = '0;

    // Basic single-bench pass on RUN edge 1.
    start_a("t1");
    finish_a = 1'b1;
    tick();
    check_a("t1.verdict", 0, 1, 1, 0, 0, 1, 1);

    // Timeout with no finish, then late inputs must not disturb the verdict.
    finish_a = 1'b0;
    start_a("t3");
    repeat (4) tick();
    check("t3.not_done", 32'(done_a), 32'd0);
    check("t3.pass_low", 32'(pass_a), 32'd0);
    tick();
    check_a("t3.verdict", 0, 1, 0, 1, 0, 0, 5);
    finish_a = 1'b1; fail_a = 1'b1;
    repeat (2) tick();
    check_a("t3.frozen", 0, 1, 0, 1, 0, 0, 5);

    // Finish on the timeout edge wins.
    finish_a = 1'b0; fail_a = 1'b0;
    start_a("t4");
    repeat (4) tick();
    finish_a = 1'b1;
    tick();
    check_a("t4.verdict", 0, 1, 1, 0, 0, 1, 5);

    // fail/finish held during RST are ignored until RUN.
    fail_a = 1'b1; finish_a = 1'b1;
    start_a("t5");
    tick();
    check_a("t5.verdict", 0, 1, 0, 0, 1, 1, 1);

    // Reset mid-RUN and again in DONE.
    fail_a = 1'b0; finish_a = 1'b0;
    start_a("t6");
    repeat (2) tick();
    check("t6.cycles2", cycles_a, 32'd2);
    reset_a = 1'b1;
    tick();
    check_a("t6.midrun_rst", 1, 0, 0, 0, 0, 0, 0);
    start_a("t6b");
    finish_a = 1'b1;
    tick();
    check_a("t6b.verdict", 0, 1, 1, 0, 0, 1, 1);
    reset_a = 1'b1;
    tick();
    check_a("t6.done_rst", 1, 0, 0, 0, 0, 0, 0);
    finish_a = 1'b0;

    // Two benches: bench 0 fails+finishes at edge 1, bench 1 finishes at edge 4.
    start_b("t2");
    for (int e = 1; e <= 4; e++) begin
      fail_b   = 2'b01;
      finish_b = (e >= 4) ? 2'b11 : 2'b01;
      tick();
      if (e < 4) check("t2.not_done", 32'(done_b), 32'd0);
    end
    check("t2.done", 32'(done_b), 32'd1);
    check("t2.fail_mask", 32'(fail_mask_b), 32'd1);
    check("t2.finish_mask", 32'(finish_mask_b), 32'd3);
    check("t2.pass", 32'(pass_b), 32'd0);
    check("t2.cycles", cycles_b, 32'd4);

    // Randomized scenarios: each bench finishes (and maybe fails) at a
    // random RUN edge; the verdict follows from those edges alone.
    for (int it = 0; it < 24; it++) begin
      fail_b = '0; finish_b = '0;
      for (int i = 0; i < 2; i++) begin
        fe[i] = int'($urandom_range(1, 16));
        fl[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : 1000;
      end
      last  = (fe[0] > fe[1]) ? fe[0] : fe[1];
      tmo   = last > TMO_B;
      fin_e = tmo ? TMO_B : last;
      for (int i = 0; i < 2; i++) begin
        fm[i] = fl[i] <= fin_e;
        nm[i] = fe[i] <= fin_e;
      end
      start_b("rnd");
      for (int e = 1; e <= 18; e++) begin
        for (int i = 0; i < 2; i++) begin
          finish_b[i] = e >= fe[i];
          fail_b[i]   = e >= fl[i];
        end
        tick();
        if (e < fin_e) begin
          check("rnd.not_done", 32'(done_b), 32'd0);
          check("rnd.pass_low", 32'(pass_b), 32'd0);
          check("rnd.cycles_run", cycles_b, 32'(e));
        end else begin
          check("rnd.done", 32'(done_b), 32'd1);
          check("rnd.timeout", 32'(timeout_b), 32'(tmo));
          check("rnd.pass", 32'(pass_b), 32'(!tmo && fm == 2'b00));
          check("rnd.fail_mask", 32'(fail_mask_b), 32'(fm));
          check("rnd.finish_mask", 32'(finish_mask_b), 32'(nm));
          check("rnd.cycles", cycles_b, 32'(fin_e));
          check("rnd.dut_reset", 32'(dut_reset_b), 32'd0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
